// File: rtl/rv32_ex_operand_stage.sv
// ID/EX operand stage: 2-entry skid buffer feeding the ALU with opA/opB/opsel.
// Build with RV32_EX_FWD_EN defined to enable EX/MEM + WB forwarding and snoop.
module rv32_ex_operand_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_opsel,
    input  logic [1:0]      in_opa_sel,
    input  logic [1:0]      in_opb_sel,
    input  logic [4:0]      in_rs1_idx,
    input  logic [4:0]      in_rs2_idx,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    input  logic [4:0]      in_rd_idx,
    input  logic            fwd_mem_we,
    input  logic [4:0]      fwd_mem_idx,
    input  logic [XLEN-1:0] fwd_mem_data,
    input  logic            fwd_wb_we,
    input  logic [4:0]      fwd_wb_idx,
    input  logic [XLEN-1:0] fwd_wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      alu_opsel,
    output logic [XLEN-1:0] opA,
    output logic [XLEN-1:0] opB,
    output logic [4:0]      out_rd_idx
);

    typedef struct packed {
        logic [3:0]      opsel;
        logic [1:0]      opa_sel;
        logic [1:0]      opb_sel;
        logic [4:0]      rs1_idx;
        logic [4:0]      rs2_idx;
        logic [4:0]      rd_idx;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
    } entry_t;

    entry_t     buf_q [DEPTH];
    entry_t     cap;
    entry_t     head;
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count_q;
    logic [1:0] count_nxt;
    logic       push;
    logic       pop;

    // x0 always reads zero; MEM result is younger than WB so it wins.
    function automatic logic [XLEN-1:0] resolve(
        input logic [4:0]      idx,
        input logic [XLEN-1:0] data
    );
`ifdef RV32_EX_FWD_EN
        if (idx == 5'd0)
            resolve = '0;
        else if (fwd_mem_we && fwd_mem_idx == idx)
            resolve = fwd_mem_data;
        else if (fwd_wb_we && fwd_wb_idx == idx)
            resolve = fwd_wb_data;
        else
            resolve = data;
`else
        resolve = (idx == 5'd0) ? '0 : data;
`endif
    endfunction

`ifndef RV32_EX_FWD_EN
    logic unused_fwd;
    assign unused_fwd = ^{fwd_mem_we, fwd_mem_idx, fwd_mem_data,
                          fwd_wb_we, fwd_wb_idx, fwd_wb_data};
`endif

    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        count_nxt = count_q;
        case ({push, pop})
            2'b10:   count_nxt = count_q + 2'd1;
            2'b01:   count_nxt = count_q - 2'd1;
            default: count_nxt = count_q;
        endcase
    end

    always_comb begin
        cap          = '0;
        cap.opsel    = in_opsel;
        cap.opa_sel  = in_opa_sel;
        cap.opb_sel  = in_opb_sel;
        cap.rs1_idx  = in_rs1_idx;
        cap.rs2_idx  = in_rs2_idx;
        cap.rd_idx   = in_rd_idx;
        cap.rs1_data = resolve(in_rs1_idx, in_rs1_data);
        cap.rs2_data = resolve(in_rs2_idx, in_rs2_data);
        cap.pc       = in_pc;
        cap.imm      = in_imm;
    end

`ifdef RV32_EX_FWD_EN
    logic [DEPTH-1:0] ent_valid;

    always_comb begin
        ent_valid = '0;
        if (count_q == 2'd2)
            ent_valid = '1;
        else if (count_q == 2'd1)
            ent_valid[rd_ptr] = 1'b1;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            in_ready <= 1'b1;
            for (int i = 0; i < DEPTH; i++)
                buf_q[i] <= '0;
        end else if (flush) begin
            count_q  <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            in_ready <= 1'b1;
        end else begin
`ifdef RV32_EX_FWD_EN
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_valid[i]) begin
                    buf_q[i].rs1_data <= resolve(buf_q[i].rs1_idx,
                                                 buf_q[i].rs1_data);
                    buf_q[i].rs2_data <= resolve(buf_q[i].rs2_idx,
                                                 buf_q[i].rs2_data);
                end
            end
`endif
            // Capture is written last so it overrides any snoop of that slot.
            if (push) begin
                buf_q[wr_ptr] <= cap;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count_q  <= count_nxt;
            in_ready <= (count_nxt < 2'd2);
        end
    end

    assign head = buf_q[rd_ptr];

    always_comb begin
        alu_opsel  = '0;
        opA        = '0;
        opB        = '0;
        out_rd_idx = '0;
        if (out_valid) begin
            alu_opsel  = head.opsel;
            out_rd_idx = head.rd_idx;
            case (head.opa_sel)
                2'd0:    opA = head.rs1_data;
                2'd1:    opA = head.pc;
                default: opA = '0;
            endcase
            case (head.opb_sel)
                2'd0:    opB = head.rs2_data;
                2'd1:    opB = head.imm;
                2'd2:    opB = XLEN'(4);
                default: opB = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_ex_operand_stage.sv
// Directed scoreboard bench for rv32_ex_operand_stage.
// Expected operands follow the RV32_EX_FWD_EN setting of the build.
module tb_rv32_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready;
    logic [3:0]  in_opsel;
    logic [1:0]  in_opa_sel, in_opb_sel;
    logic [4:0]  in_rs1_idx, in_rs2_idx, in_rd_idx;
    logic [31:0] in_rs1_data, in_rs2_data, in_pc, in_imm;
    logic        fwd_mem_we, fwd_wb_we;
    logic [4:0]  fwd_mem_idx, fwd_wb_idx;
    logic [31:0] fwd_mem_data, fwd_wb_data;
    logic        out_valid, out_ready;
    logic [3:0]  alu_opsel;
    logic [31:0] opA, opB;
    logic [4:0]  out_rd_idx;

    typedef struct {
        logic [3:0]  opsel;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;

`ifdef RV32_EX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    always #5 clk = ~clk;

    rv32_ex_operand_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opsel(in_opsel), .in_opa_sel(in_opa_sel),
        .in_opb_sel(in_opb_sel),
        .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_pc(in_pc), .in_imm(in_imm), .in_rd_idx(in_rd_idx),
        .fwd_mem_we(fwd_mem_we), .fwd_mem_idx(fwd_mem_idx),
        .fwd_mem_data(fwd_mem_data),
        .fwd_wb_we(fwd_wb_we), .fwd_wb_idx(fwd_wb_idx),
        .fwd_wb_data(fwd_wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_opsel(alu_opsel), .opA(opA), .opB(opB),
        .out_rd_idx(out_rd_idx)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        in_valid = 0; in_opsel = 0; in_opa_sel = 0; in_opb_sel = 0;
        in_rs1_idx = 0; in_rs2_idx = 0; in_rs1_data = 0; in_rs2_data = 0;
        in_pc = 0; in_imm = 0; in_rd_idx = 0;
        fwd_mem_we = 0; fwd_mem_idx = 0; fwd_mem_data = 0;
        fwd_wb_we = 0; fwd_wb_idx = 0; fwd_wb_data = 0;
    endtask

    task automatic drive(input logic [3:0] op, input logic [1:0] asel,
                         input logic [4:0] r1, input logic [31:0] d1,
                         input logic [1:0] bsel,
                         input logic [4:0] r2, input logic [31:0] d2,
                         input logic [31:0] pc, input logic [31:0] imm,
                         input logic [4:0] rd);
        in_valid = 1; in_opsel = op; in_opa_sel = asel; in_opb_sel = bsel;
        in_rs1_idx = r1; in_rs1_data = d1; in_rs2_idx = r2; in_rs2_data = d2;
        in_pc = pc; in_imm = imm; in_rd_idx = rd;
    endtask

    task automatic expect_out(input logic [3:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] rd);
        exp_t e;
        e.opsel = op; e.a = a; e.b = b; e.rd = rd;
        q.push_back(e);
    endtask

    // Called at a negedge: compare a consumed head, then advance one clock.
    task automatic cycle();
        exp_t e;
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("sb_unexpected_pop", 32'(out_valid), 32'd0);
            end else begin
                e = q.pop_front();
                chk("sb_opsel", 32'(alu_opsel), 32'(e.opsel));
                chk("sb_opA", opA, e.a);
                chk("sb_opB", opB, e.b);
                chk("sb_rd", 32'(out_rd_idx), 32'(e.rd));
            end
        end
        @(negedge clk);
    endtask

    initial begin
        idle();
        rst = 1; flush = 0; out_ready = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_opsel", 32'(alu_opsel), 32'd0);
        chk("rst_opA", opA, 32'd0);
        chk("rst_opB", opB, 32'd0);
        chk("rst_rd", 32'(out_rd_idx), 32'd0);
        rst = 0;
        cycle();

        // basic rs1 + imm, one-cycle latency
        out_ready = 1;
        drive(4'd0, 2'd0, 5'd3, 32'd10, 2'd1, 5'd4, 32'd99, 32'd0, 32'd5, 5'd1);
        expect_out(4'd0, 32'd10, 32'd5, 5'd1);
        cycle();
        idle();
        chk("latency_valid", 32'(out_valid), 32'd1);
        cycle();
        chk("drained_valid", 32'(out_valid), 32'd0);

        // MEM beats WB on the same index
        drive(4'd2, 2'd0, 5'd5, 32'd1, 2'd2, 5'd6, 32'd7, 32'd0, 32'd0, 5'd2);
        fwd_mem_we = 1; fwd_mem_idx = 5; fwd_mem_data = 32'h100;
        fwd_wb_we = 1; fwd_wb_idx = 5; fwd_wb_data = 32'h200;
        expect_out(4'd2, FWD ? 32'h100 : 32'd1, 32'd4, 5'd2);
        cycle();
        idle();

        // WB-only forward on rs2
        drive(4'd3, 2'd2, 5'd1, 32'd9, 2'd0, 5'd7, 32'd3, 32'd0, 32'd0, 5'd3);
        fwd_wb_we = 1; fwd_wb_idx = 7; fwd_wb_data = 32'h99;
        expect_out(4'd3, 32'd0, FWD ? 32'h99 : 32'd3, 5'd3);
        cycle();
        idle();

        // x0 never forwarded
        drive(4'd1, 2'd2, 5'd0, 32'hAB, 2'd0, 5'd0, 32'hFFFF, 32'd0, 32'd0, 5'd4);
        fwd_mem_we = 1; fwd_mem_idx = 0; fwd_mem_data = 32'h77;
        expect_out(4'd1, 32'd0, 32'd0, 5'd4);
        cycle();
        idle();

        // reserved selects read as zero
        drive(4'hF, 2'd3, 5'd2, 32'h5, 2'd3, 5'd2, 32'h6, 32'h40, 32'h8, 5'd31);
        expect_out(4'hF, 32'd0, 32'd0, 5'd31);
        cycle();
        idle();
        cycle();
        chk("q_empty_1", 32'(q.size()), 32'd0);

        // stall: fill, third push dropped, snoop into entry 2
        out_ready = 0;
        drive(4'd4, 2'd0, 5'd8, 32'h11, 2'd1, 5'd0, 32'd0, 32'd0, 32'd1, 5'd2);
        expect_out(4'd4, 32'h11, 32'd1, 5'd2);
        cycle();
        chk("stall_ready1", 32'(in_ready), 32'd1);
        drive(4'd5, 2'd0, 5'd9, 32'h22, 2'd1, 5'd0, 32'd0, 32'd0, 32'd2, 5'd3);
        expect_out(4'd5, FWD ? 32'h55 : 32'h22, 32'd2, 5'd3);
        cycle();
        chk("stall_ready0", 32'(in_ready), 32'd0);
        drive(4'd6, 2'd0, 5'd10, 32'h33, 2'd1, 5'd0, 32'd0, 32'd0, 32'd3, 5'd4);
        fwd_wb_we = 1; fwd_wb_idx = 9; fwd_wb_data = 32'h55;
        cycle();
        idle();
        chk("stall_hold_opA", opA, 32'h11);
        chk("stall_hold_rd", 32'(out_rd_idx), 32'd2);
        out_ready = 1;
        cycle();
        cycle();
        chk("third_dropped", 32'(out_valid), 32'd0);

        // AUIPC then JAL link back to back
        drive(4'd7, 2'd1, 5'd0, 32'd0, 2'd1, 5'd0, 32'd0, 32'h1000, 32'h2000, 5'd5);
        expect_out(4'd7, 32'h1000, 32'h2000, 5'd5);
        cycle();
        drive(4'd0, 2'd1, 5'd0, 32'd0, 2'd2, 5'd0, 32'd0, 32'h1004, 32'd0, 5'd1);
        expect_out(4'd0, 32'h1004, 32'd4, 5'd1);
        cycle();
        idle();
        chk("b2b_valid", 32'(out_valid), 32'd1);
        cycle();
        chk("q_empty_2", 32'(q.size()), 32'd0);

        // flush with a full buffer and in_valid high
        out_ready = 0;
        drive(4'd1, 2'd0, 5'd1, 32'hA, 2'd1, 5'd0, 32'd0, 32'd0, 32'd1, 5'd1);
        cycle();
        drive(4'd1, 2'd0, 5'd1, 32'hB, 2'd1, 5'd0, 32'd0, 32'd0, 32'd1, 5'd1);
        cycle();
        chk("pre_flush_ready", 32'(in_ready), 32'd0);
        flush = 1;
        drive(4'd2, 2'd0, 5'd1, 32'hC, 2'd1, 5'd0, 32'd0, 32'd0, 32'd1, 5'd1);
        cycle();
        flush = 0;
        idle();
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_ready", 32'(in_ready), 32'd1);
        out_ready = 1;
        drive(4'd9, 2'd0, 5'd12, 32'h123, 2'd0, 5'd13, 32'h456, 32'd0, 32'd0, 5'd6);
        expect_out(4'd9, 32'h123, 32'h456, 5'd6);
        cycle();
        idle();
        cycle();

        // reset mid-stream
        out_ready = 0;
        drive(4'd3, 2'd0, 5'd1, 32'hD, 2'd1, 5'd0, 32'd0, 32'd0, 32'd1, 5'd1);
        cycle();
        cycle();
        rst = 1;
        cycle();
        rst = 0;
        idle();
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_ready", 32'(in_ready), 32'd1);
        chk("mrst_opA", opA, 32'd0);
        chk("mrst_opsel", 32'(alu_opsel), 32'd0);
        out_ready = 1;
        drive(4'd8, 2'd0, 5'd14, 32'h777, 2'd1, 5'd0, 32'd0, 32'd0, 32'h10, 5'd7);
        expect_out(4'd8, 32'h777, 32'h10, 5'd7);
        cycle();
        idle();
        cycle();
        chk("q_empty_end", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
